// File: rtl/score_digit_scan.sv
// Four-digit BCD score counter with saturation and a time-multiplexed
// seven-segment digit scanner (registered digit/anode outputs).

module score_digit_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= 4'd0;
    else if (clr) q <= 4'd0;
    else if (en)  q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
  end
endmodule

module score_digit_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] score_bcd,
  output logic        sat,
  output logic [3:0]  digit,
  output logic [3:0]  an_n
);
  localparam int NUM_DIGITS = 4;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      carry;
  logic                       full;

  assign full      = (nib == 16'h9999);
  assign score_bcd = nib;

  // Increment enable ripples up as a decimal carry; frozen once at 9999.
  assign carry[0] = inc & ~full;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      score_digit_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (carry[g]),
        .q     (nib[g])
      );
      if (g < NUM_DIGITS - 1) begin : g_carry
        assign carry[g+1] = carry[g] & (nib[g] == 4'd9);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)          sat <= 1'b0;
    else if (clr)        sat <= 1'b0;
    else if (inc & full) sat <= 1'b1;
  end

  // Scan timing: free-running, independent of score activity.
  logic [PW-1:0] pre;
  logic [1:0]    slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      slot <= 2'd0;
    end else if (pre == PRE_MAX) begin
      pre  <= '0;
      slot <= slot + 2'd1;
    end else begin
      pre  <= pre + 1'b1;
    end
  end

  // lz[k]: nibbles k..3 are all zero, so slot k is a leading zero.
  logic [NUM_DIGITS-1:1] lz;
  assign lz[3] = (nib[3] == 4'd0);
  generate
    for (g = 1; g < NUM_DIGITS - 1; g++) begin : g_lz
      assign lz[g] = (nib[g] == 4'd0) & lz[g+1];
    end
  endgenerate

  logic [3:0] digit_nxt;
  logic [3:0] an_nxt;
  logic       blank;

  always_comb begin
    blank     = 1'b0;
    if (BLANK_LEADING && slot != 2'd0) blank = lz[slot];
    digit_nxt = nib[slot];
    an_nxt    = ~(4'b0001 << slot);
    if (blank) begin
      digit_nxt = 4'd0;
      an_nxt    = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= 4'd0;
      an_n  <= 4'b1110;
    end else begin
      digit <= digit_nxt;
      an_n  <= an_nxt;
    end
  end
endmodule

// File: tb/tb_score_digit_scan.sv
// Randomized bench for score_digit_scan (SCAN_DIV=4), blanking and
// non-blanking instances, against an integer-arithmetic reference model.

module tb_score_digit_scan;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] score_b, score_n;
  logic        sat_b, sat_n;
  logic [3:0]  digit_b, digit_n, an_b, an_n;

  int errors = 0;
  int checks = 0;

  // Reference state: integer score, sticky flag, edges since reset.
  int m_score = 0;
  bit m_sat = 1'b0;
  int m_n = 0;
  logic [7:0] m_disp_b = {4'b1110, 4'd0};
  logic [7:0] m_disp_n = {4'b1110, 4'd0};

  always #5 clk = ~clk;

  score_digit_scan #(.SCAN_DIV(DIV), .BLANK_LEADING(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .score_bcd(score_b), .sat(sat_b), .digit(digit_b), .an_n(an_b)
  );

  score_digit_scan #(.SCAN_DIV(DIV), .BLANK_LEADING(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .score_bcd(score_n), .sat(sat_n), .digit(digit_n), .an_n(an_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int p;
    b = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      b[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  // {an_n, digit} for the slot active after n scan edges and a given score.
  function automatic logic [7:0] disp(input int n, input int sc, input bit bl);
    int slot, p, d;
    logic [3:0] sel;
    slot = (n / DIV) % 4;
    p = 1;
    for (int k = 0; k < slot; k++) p = p * 10;
    d = (sc / p) % 10;
    if (bl && slot > 0 && sc < p) return {4'b1111, 4'd0};
    sel = 4'b0001 << slot;
    return {~sel, 4'(d)};
  endfunction

  task automatic step(input bit i, input bit c, input bit r);
    inc   = i;
    clr   = c;
    rst_n = ~r;
    @(posedge clk);
    if (r) begin
      m_score = 0; m_sat = 1'b0; m_n = 0;
      m_disp_b = {4'b1110, 4'd0};
      m_disp_n = {4'b1110, 4'd0};
    end else begin
      m_disp_b = disp(m_n, m_score, 1'b1);
      m_disp_n = disp(m_n, m_score, 1'b0);
      m_n++;
      if (c) begin
        m_score = 0; m_sat = 1'b0;
      end else if (i) begin
        if (m_score == 9999) m_sat = 1'b1;
        else m_score++;
      end
    end
    #1;
    chk("score_b", score_b, to_bcd(m_score));
    chk("score_n", score_n, to_bcd(m_score));
    chk("sat", sat_b, m_sat);
    chk("digit_b", digit_b, m_disp_b[3:0]);
    chk("an_b", an_b, m_disp_b[7:4]);
    chk("digit_n", digit_n, m_disp_n[3:0]);
    chk("an_n", an_n, m_disp_n[7:4]);
    chk("onehot_b", 32'($countones(~an_b) <= 1), 32'd1);
    chk("onehot_n", 32'($countones(~an_n) <= 1), 32'd1);
    #3;
  endtask

  task automatic idle(input int cyc);
    for (int k = 0; k < cyc; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input int v);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < v; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle scan with blanked upper slots.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_an", an_b, 4'b1110);
    chk("rst_score", score_b, 16'h0000);
    idle(40);

    // Carry chain 0099 -> 0100, watch all slots.
    load(99);
    step(1'b1, 1'b0, 1'b0);
    chk("carry100", score_b, 16'h0100);
    idle(20);

    // inc and clr together at 0042.
    load(42);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_prio", score_b, 16'h0000);

    // Non-blanking display at 0007.
    load(7);
    idle(20);

    // Saturation.
    load(9999);
    chk("at9999", score_b, 16'h9999);
    step(1'b1, 1'b0, 1'b0);
    chk("sat_set", sat_b, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    chk("sat_hold", score_b, 16'h9999);
    idle(16);
    step(1'b0, 1'b1, 1'b0);
    chk("sat_clr", sat_b, 1'b0);

    // Reset mid-slot 2 at 1234.
    load(1234);
    for (int k = 0; k < 4 * DIV && !(((m_n / DIV) % 4 == 2) && (m_n % DIV == 1)); k++)
      step(1'b0, 1'b0, 1'b0);
    chk("slot2_reached", 32'(((m_n / DIV) % 4 == 2) && (m_n % DIV == 1)), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("midrst_an", an_b, 4'b1110);
    idle(20);

    // Random traffic from zero and from near saturation.
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, $urandom_range(0, 249) == 0);
    load(9985);
    for (int k = 0; k < 200; k++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
